// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage RV32I pipeline.
// Decodes the ID/EX/MEM/WB instructions and sequences the data-memory handshake.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    input  logic [31:0] mem_instr,
    input  logic [31:0] wb_instr,
    input  logic        ex_redirect,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic        mem_fault,
    output logic [31:0] stall_cycles
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

    function automatic logic writes_rd(input logic [31:0] instr);
        logic hit;
        case (instr[6:0])
            OP_REG, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: hit = 1'b1;
            default:                                                    hit = 1'b0;
        endcase
        return hit && (instr[11:7] != 5'd0);
    endfunction

    function automatic logic uses_rs1(input logic [31:0] instr);
        logic hit;
        case (instr[6:0])
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: hit = 1'b1;
            default:                                               hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic uses_rs2(input logic [31:0] instr);
        logic hit;
        case (instr[6:0])
            OP_REG, OP_STORE, OP_BRANCH: hit = 1'b1;
            default:                     hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_load(input logic [31:0] instr);
        return instr[6:0] == OP_LOAD;
    endfunction

    function automatic logic is_mem(input logic [31:0] instr);
        return (instr[6:0] == OP_LOAD) || (instr[6:0] == OP_STORE);
    endfunction

    mem_state_t  state;
    mem_state_t  next_state;
    logic [15:0] wait_cnt;
    logic        mem_stall;
    logic        timeout_hit;
    logic        load_use;
    logic        mem_fwd_ok;
    logic        wb_fwd_ok;

    // Load in EX whose destination the ID instruction actually reads.
    assign load_use = is_load(ex_instr) && writes_rd(ex_instr) &&
                      ((uses_rs1(id_instr) && (id_instr[19:15] == ex_instr[11:7])) ||
                       (uses_rs2(id_instr) && (id_instr[24:20] == ex_instr[11:7])));

    // A load in MEM has no result yet, so only non-load writers forward from EX/MEM.
    assign mem_fwd_ok = writes_rd(mem_instr) && !is_load(mem_instr);
    assign wb_fwd_ok  = writes_rd(wb_instr);

    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (mem_fwd_ok && (mem_instr[11:7] == ex_instr[19:15])) begin
            forward_a = 2'b10;
        end else if (wb_fwd_ok && (wb_instr[11:7] == ex_instr[19:15])) begin
            forward_a = 2'b01;
        end
        if (mem_fwd_ok && (mem_instr[11:7] == ex_instr[24:20])) begin
            forward_b = 2'b10;
        end else if (wb_fwd_ok && (wb_instr[11:7] == ex_instr[24:20])) begin
            forward_b = 2'b01;
        end
    end

    // The ack cycle and the timeout cycle both release the pipeline.
    always_comb begin
        next_state  = state;
        dmem_req    = 1'b0;
        mem_stall   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = is_mem(mem_instr);
                if (dmem_req && !dmem_ack) begin
                    next_state = BUSY;
                    mem_stall  = 1'b1;
                end
            end
            BUSY: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    next_state = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state  = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            mem_fault <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= ((state == BUSY) && (next_state == BUSY)) ? wait_cnt + 16'd1 : 16'd0;
            mem_fault <= mem_fault | timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
        end else if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// instruction streams, all checked against a behavioural pipeline-control model.
module tb_pipeline_hazard_ctrl;

    localparam int          TIMEOUT = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] LW_X5   = 32'h0000_A283;  // lw   x5,0(x1)
    localparam logic [31:0] ADD_X6  = 32'h0022_8333;  // add  x6,x5,x2
    localparam logic [31:0] ADDI_X3A = 32'h0010_0193; // addi x3,x0,1
    localparam logic [31:0] ADDI_X3B = 32'h0020_0193; // addi x3,x0,2
    localparam logic [31:0] ADDI_X0 = 32'h0010_0013;  // addi x0,x0,1
    localparam logic [31:0] ADD_X4  = 32'h0031_8233;  // add  x4,x3,x3
    localparam logic [31:0] SW_X2   = 32'h0020_A023;  // sw   x2,0(x1)
    localparam logic [31:0] JAL_X1  = 32'h0080_00EF;  // jal  x1,8

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr, ex_instr, mem_instr, wb_instr;
    logic        ex_redirect, dmem_ack;
    logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    bit          m_busy;
    int          m_busy_cycles;
    bit          m_fault;
    logic [31:0] m_stalls;
    logic [31:0] base;

    logic        e_req, e_stall, e_timeout;
    logic        e_pc, e_ifid, e_idex, e_exmem, e_fl_ifid, e_fl_idex, e_bubble;
    logic [1:0]  e_fa, e_fb;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_instr(id_instr), .ex_instr(ex_instr), .mem_instr(mem_instr), .wb_instr(wb_instr),
        .ex_redirect(ex_redirect), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
        .forward_a(forward_a), .forward_b(forward_b), .mem_fault(mem_fault),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit m_writes(input logic [31:0] i);
        return (i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                               7'b1100111, 7'b0110111, 7'b0010111}) && (i[11:7] != 5'd0);
    endfunction

    function automatic bit m_uses1(input logic [31:0] i);
        return i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1100111};
    endfunction

    function automatic bit m_uses2(input logic [31:0] i);
        return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit m_is_load(input logic [31:0] i);
        return i[6:0] == 7'b0000011;
    endfunction

    function automatic bit m_is_mem(input logic [31:0] i);
        return (i[6:0] == 7'b0000011) || (i[6:0] == 7'b0100011);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic [31:0] mi,
                                         input logic [31:0] wi);
        if (m_writes(mi) && !m_is_load(mi) && mi[11:7] == rs) return 2'b10;
        if (m_writes(wi) && wi[11:7] == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] id, input logic [31:0] ex,
                                  input logic [31:0] mem, input logic [31:0] wb,
                                  input logic redir, input logic ack);
        id_instr    = id;
        ex_instr    = ex;
        mem_instr   = mem;
        wb_instr    = wb;
        ex_redirect = redir;
        dmem_ack    = ack;
    endtask

    task automatic model_reset();
        m_busy        = 1'b0;
        m_busy_cycles = 0;
        m_fault       = 1'b0;
        m_stalls      = 32'd0;
    endtask

    // Expected controls: a memory access stalls until ack or TIMEOUT busy cycles.
    task automatic predict();
        bit lu;
        e_timeout = 1'b0;
        if (!m_busy) begin
            e_req   = m_is_mem(mem_instr);
            e_stall = e_req && !dmem_ack;
        end else begin
            e_req = 1'b1;
            if (dmem_ack) begin
                e_stall = 1'b0;
            end else if (m_busy_cycles + 1 >= TIMEOUT) begin
                e_stall   = 1'b0;
                e_timeout = 1'b1;
            end else begin
                e_stall = 1'b1;
            end
        end
        lu = m_is_load(ex_instr) && m_writes(ex_instr) &&
             ((m_uses1(id_instr) && id_instr[19:15] == ex_instr[11:7]) ||
              (m_uses2(id_instr) && id_instr[24:20] == ex_instr[11:7]));
        {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        {e_fl_ifid, e_fl_idex, e_bubble} = 3'b000;
        if (e_stall) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            e_bubble = 1'b1;
        end else if (ex_redirect) begin
            {e_fl_ifid, e_fl_idex} = 2'b11;
        end else if (lu) begin
            {e_pc, e_ifid} = 2'b00;
            e_fl_idex = 1'b1;
        end
        e_fa = m_fwd(ex_instr[19:15], mem_instr, wb_instr);
        e_fb = m_fwd(ex_instr[24:20], mem_instr, wb_instr);
    endtask

    task automatic check_cycle();
        @(negedge clk);
        predict();
        check_output("dmem_req", 32'(dmem_req), 32'(e_req));
        check_output("pc_en", 32'(pc_en), 32'(e_pc));
        check_output("if_id_en", 32'(if_id_en), 32'(e_ifid));
        check_output("id_ex_en", 32'(id_ex_en), 32'(e_idex));
        check_output("ex_mem_en", 32'(ex_mem_en), 32'(e_exmem));
        check_output("if_id_flush", 32'(if_id_flush), 32'(e_fl_ifid));
        check_output("id_ex_flush", 32'(id_ex_flush), 32'(e_fl_idex));
        check_output("mem_wb_bubble", 32'(mem_wb_bubble), 32'(e_bubble));
        check_output("forward_a", 32'(forward_a), 32'(e_fa));
        check_output("forward_b", 32'(forward_b), 32'(e_fb));
        check_output("mem_fault", 32'(mem_fault), 32'(m_fault));
        check_output("stall_cycles", stall_cycles, m_stalls);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (!e_pc && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
            if (e_timeout) m_fault = 1'b1;
            if (m_busy) begin
                if (dmem_ack || e_timeout) begin
                    m_busy        = 1'b0;
                    m_busy_cycles = 0;
                end else begin
                    m_busy_cycles++;
                end
            end else if (e_req && !dmem_ack) begin
                m_busy = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(NOP, NOP, NOP, NOP, 1'b0, 1'b0);
        model_reset();
        check_cycle();
        check_output("reset_stall_cycles", stall_cycles, 32'd0);
        check_output("reset_pc_en", 32'(pc_en), 32'd1);
        advance();
        rst_n = 1'b1;

        $display("[TB] load-use");
        apply_stimulus(ADD_X6, LW_X5, NOP, NOP, 1'b0, 1'b0);
        check_cycle();
        check_output("lu_pc_en", 32'(pc_en), 32'd0);
        check_output("lu_if_id_en", 32'(if_id_en), 32'd0);
        check_output("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        advance();
        apply_stimulus(ADD_X6, NOP, LW_X5, NOP, 1'b0, 1'b1);
        check_cycle();
        check_output("lu_stall_count", stall_cycles, 32'd1);
        check_output("lu_released", 32'(pc_en), 32'd1);
        advance();
        apply_stimulus(NOP, ADD_X6, NOP, LW_X5, 1'b0, 1'b0);
        check_cycle();
        check_output("lu_fwd_a_wb", 32'(forward_a), 32'd1);
        check_output("lu_fwd_b_rf", 32'(forward_b), 32'd0);
        advance();

        $display("[TB] forwarding priority");
        apply_stimulus(NOP, ADD_X4, ADDI_X3A, ADDI_X3B, 1'b0, 1'b0);
        check_cycle();
        check_output("prio_fwd_a", 32'(forward_a), 32'd2);
        check_output("prio_fwd_b", 32'(forward_b), 32'd2);
        advance();
        apply_stimulus(NOP, ADD_X4, ADDI_X0, ADDI_X3B, 1'b0, 1'b0);
        check_cycle();
        check_output("x0_fwd_a", 32'(forward_a), 32'd1);
        check_output("x0_fwd_b", 32'(forward_b), 32'd1);
        advance();

        $display("[TB] memory wait");
        base = m_stalls;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(NOP, NOP, SW_X2, NOP, 1'b0, c == 2);
            check_cycle();
            check_output("wait_req", 32'(dmem_req), 32'd1);
            check_output("wait_bubble", 32'(mem_wb_bubble), (c == 2) ? 32'd0 : 32'd1);
            check_output("wait_pc_en", 32'(pc_en), (c == 2) ? 32'd1 : 32'd0);
            advance();
        end
        apply_stimulus(NOP, NOP, NOP, SW_X2, 1'b0, 1'b0);
        check_cycle();
        check_output("wait_stall_count", stall_cycles, base + 32'd2);
        advance();

        $display("[TB] redirect during memory stall");
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(NOP, JAL_X1, SW_X2, NOP, 1'b1, c == 2);
            check_cycle();
            check_output("redir_if_id_flush", 32'(if_id_flush), (c == 2) ? 32'd1 : 32'd0);
            check_output("redir_id_ex_flush", 32'(id_ex_flush), (c == 2) ? 32'd1 : 32'd0);
            advance();
        end

        $display("[TB] timeout");
        base = m_stalls;
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(NOP, NOP, LW_X5, NOP, 1'b0, 1'b0);
            check_cycle();
            check_output("to_pc_en", 32'(pc_en), (c == 4) ? 32'd1 : 32'd0);
            check_output("to_fault_pending", 32'(mem_fault), 32'd0);
            advance();
        end
        apply_stimulus(NOP, NOP, NOP, LW_X5, 1'b0, 1'b0);
        check_cycle();
        check_output("to_fault", 32'(mem_fault), 32'd1);
        check_output("to_idle_req", 32'(dmem_req), 32'd0);
        check_output("to_stall_count", stall_cycles, base + 32'd4);
        advance();

        $display("[TB] reset mid-stall");
        apply_stimulus(NOP, NOP, LW_X5, NOP, 1'b0, 1'b0);
        check_cycle();
        advance();
        #2;
        rst_n = 1'b0;
        model_reset();
        check_cycle();
        check_output("rst_stall_cycles", stall_cycles, 32'd0);
        check_output("rst_mem_fault", 32'(mem_fault), 32'd0);
        mem_instr = NOP;
        #1;
        check_output("rst_req_drop", 32'(dmem_req), 32'd0);
        check_output("rst_pc_en", 32'(pc_en), 32'd1);
        predict();
        advance();
        rst_n = 1'b1;

        $display("[TB] random streams");
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(rand_instr(), rand_instr(), rand_instr(), rand_instr(),
                           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
            check_cycle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
